jesd_tx_link: RTL and testbench

//  JESD204B transmit link layer for the DAC side of the board: 2 lanes, 2 octets per lane per clk (F=1).

---
 rtl/jesd_tx_link.sv | 208 ++++++++++++++++++++
 tb/tb_jesd_tx_link.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/jesd_tx_link.sv
// jesd_tx_link: JESD204B transmit link layer, 2 lanes x 2 octets/clk (F=1): CGS -> 4-MF ILAS -> user data.
// Latency: one cycle from data_i to data_o; every output is registered.
// Backpressure: no stall input; ready marks cycles whose data_i is taken at the next clk edge.
// Ports: clk, rst (async, active-low), sync_n (async, 2-flop synchronised), lmfc_edge, data_i[31:0]
//        -> data_o[31:0], datak_o[3:0] (K flag per octet), ready, sync_err, state_o[1:0] (0=CGS 1=ILAS 2=DATA).
// Build option: define JESD_TX_CHAR_REPLACE_EN to enable /F/ and /A/ character replacement in DATA.
// Lane0 = data_o[15:0], lane1 = data_o[31:16]; the low octet of each lane goes out first.
module jesd_tx_link #(
    parameter int           MF_WORDS = 16,
    parameter logic [7:0]   LANE_ID0 = 8'h00,
    parameter logic [7:0]   LANE_ID1 = 8'h01,
    parameter logic [111:0] LINK_CFG = 112'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sync_n,
    input  logic        lmfc_edge,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic [3:0]  datak_o,
    output logic        ready,
    output logic        sync_err,
    output logic [1:0]  state_o
);
    localparam int            WW        = $clog2(MF_WORDS);
    localparam logic [WW-1:0] LAST_WORD = WW'(MF_WORDS - 1);
    localparam logic [6:0]    LAST_OCT  = 7'(2 * MF_WORDS - 1);
    localparam logic [7:0]    K_R = 8'h1C, K_Q = 8'h9C, K_A = 8'h7C, K_K = 8'hBC;
    // Config octets 2..15 indexed from 0, padded to 16 so a 4-bit index is always in range.
    localparam logic [15:0][7:0] CFG_OCT = {16'h0000, LINK_CFG};

    typedef enum logic [1:0] {ST_CGS = 2'd0, ST_ILAS = 2'd1, ST_DATA = 2'd2} state_t;

    state_t        state, state_nx;
    logic          sync_q1, sync_s;
    logic [WW-1:0] wcnt, wcnt_nx;        // index of the word produced at the next edge
    logic [1:0]    mfcnt, mfcnt_nx;
    logic [2:0]    lowcnt, lowcnt_nx;    // consecutive low sync_s samples, saturates at 4
    logic [31:0]   data_nx;
    logic [3:0]    datak_nx;
    logic          ready_nx, sync_err_nx, resync;

`ifdef JESD_TX_CHAR_REPLACE_EN
    localparam logic [7:0] K_F = 8'hFC;
    logic [1:0][7:0] prev_oct, prev_oct_nx;  // previous original octet per lane
    logic [1:0]      prev_rep, prev_rep_nx;  // 1: previous octet was replaced (or none yet)
    logic [7:0]      lo, hi;
    logic            rep_lo, rep_hi;
`endif

    // One ILAS octet for octet index o of multiframe mf; returns {k, octet}.
    // In MF1 the config octets take precedence over the /A/ end marker.
    function automatic logic [8:0] ilas_oct(input logic [1:0] mf, input logic [6:0] o,
                                            input logic [7:0] lane_id);
        logic [3:0] ci;
        ci = o[3:0] - 4'd2;
        if (o == 7'd0)                                  return {1'b1, K_R};
        else if (mf == 2'd1 && o == 7'd1)               return {1'b1, K_Q};
        else if (mf == 2'd1 && o == 7'd3)               return {1'b0, lane_id};
        else if (mf == 2'd1 && o >= 7'd2 && o <= 7'd15) return {1'b0, CFG_OCT[ci]};
        else if (o == LAST_OCT)                         return {1'b1, K_A};
        else                                            return {2'b00, o};
    endfunction

    // Full ILAS word for both lanes; returns {datak[3:0], data[31:0]}.
    function automatic logic [35:0] ilas_word(input logic [1:0] mf, input logic [WW-1:0] w);
        logic [6:0] o;
        logic [8:0] l0a, l0b, l1a, l1b;
        o   = 7'({w, 1'b0});
        l0a = ilas_oct(mf, o, LANE_ID0);
        l0b = ilas_oct(mf, o + 7'd1, LANE_ID0);
        l1a = ilas_oct(mf, o, LANE_ID1);
        l1b = ilas_oct(mf, o + 7'd1, LANE_ID1);
        return {l1b[8], l1a[8], l0b[8], l0a[8], l1b[7:0], l1a[7:0], l0b[7:0], l0a[7:0]};
    endfunction

    // SYNC_N synchroniser
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q1 <= 1'b0;
            sync_s  <= 1'b0;
        end else begin
            sync_q1 <= sync_n;
            sync_s  <= sync_q1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_CGS;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        wcnt_nx   = wcnt;
        mfcnt_nx  = mfcnt;
        data_nx   = {4{K_K}};
        datak_nx  = 4'hF;
        ready_nx  = 1'b0;
        lowcnt_nx = sync_s ? 3'd0 : ((lowcnt == 3'd4) ? 3'd4 : lowcnt + 3'd1);
        // The 4th consecutive low sample drops the link back to CGS at this edge.
        resync      = (state != ST_CGS) && (lowcnt_nx == 3'd4);
        // A short low burst (1..3 samples) that has just ended.
        sync_err_nx = (state != ST_CGS) && sync_s && (lowcnt != 3'd0) && (lowcnt < 3'd4);
`ifdef JESD_TX_CHAR_REPLACE_EN
        prev_oct_nx = prev_oct;
        prev_rep_nx = prev_rep;
        lo     = 8'h00;
        hi     = 8'h00;
        rep_lo = 1'b0;
        rep_hi = 1'b0;
`endif
        case (state)
            ST_CGS: begin
                if (sync_s && lmfc_edge) begin
                    state_nx            = ST_ILAS;
                    {datak_nx, data_nx} = ilas_word(2'd0, '0);
                    wcnt_nx             = WW'(1);
                    mfcnt_nx            = 2'd0;
                end
            end
            ST_ILAS: begin
                if (resync) begin
                    state_nx = ST_CGS;
                end else begin
                    {datak_nx, data_nx} = ilas_word(mfcnt, wcnt);
                    if (wcnt == LAST_WORD) begin
                        wcnt_nx  = '0;
                        mfcnt_nx = mfcnt + 2'd1;
                        // Last ILAS word leaves now; data_i is taken from the next edge on.
                        if (mfcnt == 2'd3) begin
                            state_nx = ST_DATA;
                            ready_nx = 1'b1;
`ifdef JESD_TX_CHAR_REPLACE_EN
                            prev_rep_nx = 2'b11;
`endif
                        end
                    end else begin
                        wcnt_nx = wcnt + WW'(1);
                    end
                end
            end
            ST_DATA: begin
                if (resync) begin
                    state_nx = ST_CGS;
                end else begin
                    ready_nx = 1'b1;
                    wcnt_nx  = (wcnt == LAST_WORD) ? '0 : wcnt + WW'(1);
`ifdef JESD_TX_CHAR_REPLACE_EN
                    // Comparisons use the original octets; a replaced octet cannot trigger
                    // replacement of its successor.
                    for (int ln = 0; ln < 2; ln++) begin
                        lo     = data_i[16*ln +: 8];
                        hi     = data_i[16*ln+8 +: 8];
                        rep_lo = !prev_rep[ln] && (lo == prev_oct[ln]);
                        rep_hi = !rep_lo && (hi == lo);
                        data_nx[16*ln +: 8]   = rep_lo ? K_F : lo;
                        data_nx[16*ln+8 +: 8] = rep_hi ? ((wcnt == LAST_WORD) ? K_A : K_F) : hi;
                        datak_nx[2*ln]        = rep_lo;
                        datak_nx[2*ln+1]      = rep_hi;
                        prev_oct_nx[ln]       = hi;
                        prev_rep_nx[ln]       = rep_hi;
                    end
`else
                    data_nx  = data_i;
                    datak_nx = 4'h0;
`endif
                end
            end
            default: state_nx = ST_CGS;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wcnt     <= '0;
            mfcnt    <= 2'd0;
            lowcnt   <= 3'd0;
            data_o   <= 32'hBCBC_BCBC;
            datak_o  <= 4'hF;
            ready    <= 1'b0;
            sync_err <= 1'b0;
        end else begin
            wcnt     <= wcnt_nx;
            mfcnt    <= mfcnt_nx;
            lowcnt   <= lowcnt_nx;
            data_o   <= data_nx;
            datak_o  <= datak_nx;
            ready    <= ready_nx;
            sync_err <= sync_err_nx;
        end
    end

`ifdef JESD_TX_CHAR_REPLACE_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_oct <= '0;
            prev_rep <= 2'b11;
        end else begin
            prev_oct <= prev_oct_nx;
            prev_rep <= prev_rep_nx;
        end
    end
`endif

    assign state_o = state;

endmodule

// File: tb/tb_jesd_tx_link.sv
module tb_jesd_tx_link;
    localparam logic [111:0] CFG = 112'hADAC_ABAA_A9A8_A7A6_A5A4_A3A2_A1A0;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        sync_n = 1'b0;
    logic        lmfc_edge = 1'b0;
    logic [31:0] data_i = 32'h0;
    logic [31:0] data_o;
    logic [3:0]  datak_o;
    logic        ready, sync_err;
    logic [1:0]  state_o;

    int total = 0;
    int passed = 0;

    jesd_tx_link #(
        .MF_WORDS(16), .LANE_ID0(8'h00), .LANE_ID1(8'h01), .LINK_CFG(CFG)
    ) dut (
        .clk(clk), .rst(rst), .sync_n(sync_n), .lmfc_edge(lmfc_edge), .data_i(data_i),
        .data_o(data_o), .datak_o(datak_o), .ready(ready), .sync_err(sync_err), .state_o(state_o)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; sync_n = 1'b0; lmfc_edge = 1'b0; data_i = 32'h0;
        repeat (3) step();
        total++;
        if (data_o !== 32'hBCBC_BCBC || datak_o !== 4'hF)
            $display("FAIL reset_held: data_o=%h datak=%h, want bcbcbcbc/f", data_o, datak_o);
        else passed++;
        rst = 1'b1;
        // lmfc strobes with SYNC_N low must not start ILAS
        for (int i = 0; i < 20; i++) begin
            lmfc_edge = (i % 4 == 0);
            step();
        end
        lmfc_edge = 1'b0;
        total++;
        if (data_o !== 32'hBCBC_BCBC || datak_o !== 4'hF)
            $display("FAIL cgs_idle_data: data_o=%h datak=%h, want bcbcbcbc/f", data_o, datak_o);
        else passed++;
        total++;
        if (state_o !== 2'd0) $display("FAIL cgs_idle_state: state_o=%0d, want 0", state_o);
        else passed++;
        total++;
        if (ready !== 1'b0 || sync_err !== 1'b0)
            $display("FAIL cgs_idle_flags: ready=%b sync_err=%b, want 0/0", ready, sync_err);
        else passed++;
    endtask

    task automatic test_ilas();
        logic [31:0] ed;
        logic [3:0]  ek;
        bit          chk;
        sync_n = 1'b1;
        repeat (3) step();
        lmfc_edge = 1'b1;
        step();
        lmfc_edge = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (i > 0) step();
            chk = 1'b1;
            case (i)
                0:       begin ed = 32'h011C_011C; ek = 4'h5; end
                1:       begin ed = 32'h0302_0302; ek = 4'h0; end
                15:      begin ed = 32'h7C1E_7C1E; ek = 4'hA; end
                16:      begin ed = 32'h9C1C_9C1C; ek = 4'hF; end
                17:      begin ed = 32'h01A0_00A0; ek = 4'h0; end
                18:      begin ed = 32'hA3A2_A3A2; ek = 4'h0; end
                23:      begin ed = 32'hADAC_ADAC; ek = 4'h0; end
                24:      begin ed = 32'h1110_1110; ek = 4'h0; end
                31:      begin ed = 32'h7C1E_7C1E; ek = 4'hA; end
                32:      begin ed = 32'h011C_011C; ek = 4'h5; end
                63:      begin ed = 32'h7C1E_7C1E; ek = 4'hA; end
                default: begin ed = 32'h0; ek = 4'h0; chk = 1'b0; end
            endcase
            if (chk) begin
                total++;
                if (data_o !== ed || datak_o !== ek)
                    $display("FAIL ilas_word%0d: data_o=%h datak=%h, want %h/%h", i, data_o, datak_o, ed, ek);
                else passed++;
            end
            total++;
            if (state_o !== ((i == 63) ? 2'd2 : 2'd1) || ready !== (i == 63))
                $display("FAIL ilas_state%0d: state_o=%0d ready=%b, want %0d/%b",
                         i, state_o, ready, (i == 63) ? 2 : 1, (i == 63));
            else passed++;
        end
    endtask

    task automatic test_data();
        logic [31:0] vec [2];
        vec[0] = 32'h1234_5678;
        vec[1] = 32'hDEAD_BEEF;
        for (int i = 0; i < 2; i++) begin
            data_i = vec[i];
            step();
            total++;
            if (data_o !== vec[i] || datak_o !== 4'h0 || state_o !== 2'd2 || ready !== 1'b1)
                $display("FAIL data%0d: data_o=%h datak=%h state=%0d ready=%b, want %h/0/2/1",
                         i, data_o, datak_o, state_o, ready, vec[i]);
            else passed++;
        end
    endtask

    // Constant data from word 2 of the multiframe through word 0 of the next one.
    task automatic test_repeat_data();
        logic [31:0] ed;
        logic [3:0]  ek;
        data_i = 32'h5555_5555;
        for (int w = 2; w <= 16; w++) begin
            step();
`ifdef JESD_TX_CHAR_REPLACE_EN
            ed = (w == 15) ? 32'h7C55_7C55 : 32'hFC55_FC55;
            ek = 4'hA;
`else
            ed = 32'h5555_5555;
            ek = 4'h0;
`endif
            total++;
            if (data_o !== ed || datak_o !== ek)
                $display("FAIL repeat_w%0d: data_o=%h datak=%h, want %h/%h", w % 16, data_o, datak_o, ed, ek);
            else passed++;
        end
    endtask

    task automatic test_sync_err();
        int pulses;
        bit left;
        for (int len = 1; len <= 3; len++) begin
            pulses = 0;
            left = 1'b0;
            sync_n = 1'b0;
            repeat (len) begin
                step();
                if (sync_err === 1'b1) pulses++;
                if (state_o !== 2'd2) left = 1'b1;
            end
            sync_n = 1'b1;
            repeat (8) begin
                step();
                if (sync_err === 1'b1) pulses++;
                if (state_o !== 2'd2) left = 1'b1;
            end
            total++;
            if (pulses != 1) $display("FAIL sync_err_len%0d: pulses=%0d, want 1", len, pulses);
            else passed++;
            total++;
            if (left) $display("FAIL sync_err_state_len%0d: left DATA, want state 2 throughout", len);
            else passed++;
        end
    endtask

    task automatic test_resync();
        int  pulses = 0;
        bit  found = 1'b0;
        bit  bad = 1'b0;
        sync_n = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            if (i == 6) sync_n = 1'b1;
            step();
            if (sync_err === 1'b1) pulses++;
            if (state_o === 2'd0) found = 1'b1;
        end
        sync_n = 1'b1;
        total++;
        if (!found) $display("FAIL resync_timeout: state_o=%0d after 12 cycles, want 0", state_o);
        else passed++;
        total++;
        if (data_o !== 32'hBCBC_BCBC || datak_o !== 4'hF || ready !== 1'b0)
            $display("FAIL resync_out: data_o=%h datak=%h ready=%b, want bcbcbcbc/f/0", data_o, datak_o, ready);
        else passed++;
        // SYNC_N high without an LMFC strobe must keep CGS; low bursts in CGS are not errors
        repeat (8) begin
            step();
            if (sync_err === 1'b1) pulses++;
            if (state_o !== 2'd0 || data_o !== 32'hBCBC_BCBC) bad = 1'b1;
        end
        sync_n = 1'b0;
        repeat (2) step();
        sync_n = 1'b1;
        repeat (8) begin
            step();
            if (sync_err === 1'b1) pulses++;
            if (state_o !== 2'd0) bad = 1'b1;
        end
        total++;
        if (bad) $display("FAIL cgs_wait: left CGS without lmfc_edge, want state 0 and /K/");
        else passed++;
        total++;
        if (pulses != 0) $display("FAIL cgs_no_err: sync_err pulses=%0d, want 0", pulses);
        else passed++;
    endtask

    task automatic test_reset_mid_ilas();
        lmfc_edge = 1'b1;
        step();
        lmfc_edge = 1'b0;
        total++;
        if (data_o !== 32'h011C_011C || state_o !== 2'd1)
            $display("FAIL reilas_word0: data_o=%h state=%0d, want 011c011c/1", data_o, state_o);
        else passed++;
        repeat (5) step();
        total++;
        if (data_o !== 32'h0B0A_0B0A || datak_o !== 4'h0)
            $display("FAIL reilas_word5: data_o=%h datak=%h, want 0b0a0b0a/0", data_o, datak_o);
        else passed++;
        #2;
        rst = 1'b0;
        #1;
        total++;
        if (data_o !== 32'hBCBC_BCBC || datak_o !== 4'hF || state_o !== 2'd0 || ready !== 1'b0)
            $display("FAIL async_reset: data_o=%h datak=%h state=%0d ready=%b, want bcbcbcbc/f/0/0",
                     data_o, datak_o, state_o, ready);
        else passed++;
        repeat (2) step();
        rst = 1'b1;
        repeat (3) step();
        lmfc_edge = 1'b1;
        step();
        lmfc_edge = 1'b0;
        total++;
        if (data_o !== 32'h011C_011C || datak_o !== 4'h5 || state_o !== 2'd1)
            $display("FAIL restart_word0: data_o=%h datak=%h state=%0d, want 011c011c/5/1",
                     data_o, datak_o, state_o);
        else passed++;
        step();
        total++;
        if (data_o !== 32'h0302_0302 || datak_o !== 4'h0)
            $display("FAIL restart_word1: data_o=%h datak=%h, want 03020302/0", data_o, datak_o);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_ilas();
        test_data();
        test_repeat_data();
        test_sync_err();
        test_resync();
        test_reset_mid_ilas();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed so far", passed, total);
        $fatal(1);
    end

endmodule
